// File: rtl/regdump_tx.sv
// regdump_tx: end-of-test register-file dump transmitter.
//
// On a rising edge of `finish`, walks the register file's debug read port from register 0 to
// NREG-1 and streams a frame on a valid/ready byte interface:
//   HDR, then NREG*4 data bytes (register 0 first, MSB byte first), then an XOR checksum of
//   the data bytes.
//
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset
//   finish   - CPU end-of-program flag (edge triggered, level ignored while busy)
//   rdtaddr  - debug read port address (idx in LOAD/SEND/CSUM, 0 otherwise)
//   rdtdata  - combinational debug read data for rdtaddr
//   tx_data  - stream byte (0 when tx_valid is low)
//   tx_valid - tx_data is valid
//   tx_ready - sink accepts the byte
//   busy     - a frame is in progress
//   done     - last frame completed; held until the next trigger
module regdump_tx #(
  parameter int unsigned NREG = 32,
  parameter logic [7:0]  HDR  = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        finish,
  output logic [4:0]  rdtaddr,
  input  logic [31:0] rdtdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] LastIdx = 5'(NREG - 1);

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StLoad,
    StSend,
    StCsum
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [7:0]  csum_q, csum_d;
  logic [31:0] shreg_q, shreg_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        finish_d_q;
  logic        trigger;

  // finish_d clears on reset, so finish already high at reset release acts as an edge.
  assign trigger = finish & ~finish_d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      csum_q     <= '0;
      shreg_q    <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      finish_d_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      csum_q     <= csum_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      finish_d_q <= finish;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    csum_d   = csum_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    rdtaddr  = 5'd0;

    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          idx_d   = 5'd0;
          csum_d  = 8'h00;
          done_d  = 1'b0;
          state_d = StHdr;
        end
      end
      StHdr: begin
        tx_valid = 1'b1;
        tx_data  = HDR;
        if (tx_ready) state_d = StLoad;
      end
      StLoad: begin
        // Register contents are frozen here; later register-file writes don't leak into the frame.
        rdtaddr = idx_q;
        shreg_d = rdtdata;
        cnt_d   = 2'd0;
        state_d = StSend;
      end
      StSend: begin
        tx_valid = 1'b1;
        tx_data  = shreg_q[31:24];
        rdtaddr  = idx_q;
        if (tx_ready) begin
          csum_d  = csum_q ^ shreg_q[31:24];
          shreg_d = {shreg_q[23:0], 8'h00};
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (idx_q == LastIdx) begin
              state_d = StCsum;
            end else begin
              idx_d   = idx_q + 5'd1;
              state_d = StLoad;
            end
          end
        end
      end
      StCsum: begin
        tx_valid = 1'b1;
        tx_data  = csum_q;
        rdtaddr  = idx_q;
        if (tx_ready) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;

endmodule

// File: doc/regdump_tx.md
# regdump_tx

End-of-test register-file dump transmitter. After the pipelined CPU raises `finish`, this block walks the register file's debug read port (`rdtaddr`/`rdtdata`), reading registers 0 to NREG-1 in order. It serializes their contents as a framed byte stream on a valid/ready interface. The block sits beside the CPU top and drives the debug port the CPU only answers; a UART or testbench byte sink consumes its output.

## Interface
Clock is `clk`; reset `rst` is asynchronous and active-high.

Parameters:
- `NREG`, default 32: number of registers dumped, starting at register 0; legal range 1..32.
- `HDR`, default 8'hA5: frame header byte.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `finish` input 1: CPU end-of-program flag; may stay high for many cycles.
- `rdtaddr` output 5: register index presented to the debug read port.
- `rdtdata` input 32: combinational read data for `rdtaddr`, valid in the same cycle.
- `tx_data` output 8: stream byte.
- `tx_valid` output 1: `tx_data` is valid.
- `tx_ready` input 1: sink accepts a byte; a transfer occurs when `tx_valid` and `tx_ready` are both high at a rising edge.
- `busy` output 1: a frame is in progress.
- `done` output 1: the last frame completed; level signal.

## Operation
- Frame format:
  - `HDR`.
  - NREG×4 data bytes: register 0 first; within each register, MSB byte first (`[31:24]`, `[23:16]`, `[15:8]`, `[7:0]`).
  - One checksum byte: XOR of all data bytes (header excluded).
- Trigger:
  - A rising edge of `finish` starts a frame; `finish_d` resets to 0.
  - If `finish` is high when reset releases, that counts as a rising edge.
  - A `finish` level or edge while `busy` is ignored; no queuing.
- States:
  - IDLE: `tx_valid`=0, `busy`=0, `rdtaddr`=0. On trigger: `idx`←0, `csum`←0, `done`←0, go to HDR.
  - HDR: `tx_valid`=1, `tx_data`=`HDR`. On transfer, go to LOAD.
  - LOAD: one cycle, `tx_valid`=0, `rdtaddr`=`idx`. Capture `shreg`←`rdtdata`, byte counter←0, go to SEND.
  - SEND: `tx_valid`=1, `tx_data`=`shreg[31:24]`. On each transfer:
    - `csum`←`csum`^`tx_data`; shift `shreg` left by 8; counter+1.
    - After the 4th transfer: if `idx`==NREG-1, go to CSUM; else `idx`+1 and go to LOAD.
  - CSUM: `tx_valid`=1, `tx_data`=`csum`. On transfer: `done`←1, go to IDLE.
- `rdtaddr` equals `idx` in LOAD, SEND and CSUM, and 0 in IDLE and HDR.
- `busy` = (state != IDLE).
- `done` stays high in IDLE until the next trigger.
- Handshake rules:
  - Once `tx_valid` rises, `tx_data` and `tx_valid` hold stable until the transfer; `tx_valid` never drops without a transfer.
  - `tx_ready` may be high while `tx_valid` is low; no transfer occurs in that case.
  - `tx_data` is don't-care when `tx_valid`=0 and is driven 0 in that case.
- Arithmetic: `idx` is 5 bits, compared against NREG-1 with no wrap. `csum` is 8 bits.
- Reset mid-frame:
  - All state is cleared immediately: IDLE, `tx_valid`=0, `done`=0, `busy`=0.
  - The partial frame is abandoned; no resume.

## Timing
- Reset values: `tx_valid`=0, `tx_data`=0, `busy`=0, `done`=0, `rdtaddr`=0; state=IDLE, `idx`=0, `csum`=0, `finish_d`=0.
- Trigger latency: `finish` seen high (previous sample low) at edge t → HDR from cycle t+1, with `tx_valid`=1 and `busy`=1 in that cycle.
- With `tx_ready` held at 1:
  - HDR takes 1 cycle; each register takes 5 cycles (LOAD plus 4 SEND); CSUM takes 1 cycle.
  - Total 5·NREG+2 cycles: 162 for NREG=32, during which 130 bytes are transferred.
- `done` rises in the cycle after the checksum transfer, the same cycle `busy` falls.
- Back-pressure only stretches states; it never changes byte order or content.
- `rdtdata` is sampled only at the LOAD edge. Register-file changes after that edge do not affect the frame.

## Test plan
- Basic dump:
  - Setup: NREG=32, RF all zero except r1=0x12345678, `tx_ready`=1, pulse `finish`.
  - Required: 130 bytes A5, 00×4, 12 34 56 78, 00×120, 08; exactly 162 `busy` cycles; `done`=1 afterwards.
- Back-pressure: same RF, `tx_ready` toggling pseudo-randomly (~50%). Required: identical byte sequence; `tx_data` stable whenever `tx_valid`=1 and `tx_ready`=0.
- Level `finish`: hold `finish`=1 for 500 cycles. Required: exactly one frame; no second header; `done` stays 1.
- Re-trigger: after the first frame, drop `finish`, set r31=0xFFFFFFFF, raise `finish` again. Required:
  - `done` clears on the new trigger.
  - The frame ends FF FF FF FF, then the checksum (0x08 with r1 still 0x12345678).
- Reset mid-frame: assert `rst` during SEND of r5. Required:
  - `tx_valid`=0 immediately, `busy`=0, `done`=0.
  - A later `finish` edge produces a complete fresh frame starting with A5.
- Small NREG: NREG=1, r0=0. Required: bytes A5 00 00 00 00 00 over 7 cycles; `rdtaddr` never exceeds 0.
